// File: rtl/bt_fan_cmd_parser.sv
// Parses '<' CMD ARG '>' ASCII frames from the Bluetooth UART receiver and
// drives the fan speed, light and timer-preset registers.
module bt_fan_cmd_parser #(
  parameter int TIMEOUT_CYC = 1250000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [1:0] fan_speed,
  output logic       light_on,
  output logic [3:0] timer_val,
  output logic       timer_load,
  output logic       cmd_ok,
  output logic       cmd_err,
  output logic       busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GET_CMD = 2'd1;
  localparam logic [1:0] GET_ARG = 2'd2;
  localparam logic [1:0] GET_END = 2'd3;

  localparam logic [1:0] CMD_S = 2'd0;
  localparam logic [1:0] CMD_L = 2'd1;
  localparam logic [1:0] CMD_T = 2'd2;

  localparam logic [7:0] CH_OPEN  = 8'h3C;
  localparam logic [7:0] CH_CLOSE = 8'h3E;

  // The timeout fires on the idle cycle whose increment would reach TIMEOUT_CYC-1.
  localparam int            CW      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 2);

  logic [1:0]    state_q, state_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [3:0]    arg_q, arg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    fan_q, fan_d;
  logic          light_q, light_d;
  logic [3:0]    timer_q, timer_d;
  logic          load_q, load_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;

  logic       is_digit;
  logic [3:0] digit_val;
  logic       arg_in_range;

  always_comb begin
    is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    digit_val = rx_data[3:0];
    case (cmd_q)
      CMD_S:   arg_in_range = is_digit && (digit_val <= 4'd3);
      CMD_L:   arg_in_range = is_digit && (digit_val <= 4'd1);
      CMD_T:   arg_in_range = is_digit;
      default: arg_in_range = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    arg_d   = arg_q;
    cnt_d   = cnt_q;
    fan_d   = fan_q;
    light_d = light_q;
    timer_d = timer_q;
    load_d  = 1'b0;
    ok_d    = 1'b0;
    err_d   = 1'b0;

    if (rx_valid) begin
      cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (rx_data == CH_OPEN) state_d = GET_CMD;
        end
        GET_CMD: begin
          if (rx_data == 8'h53) begin
            cmd_d   = CMD_S;
            state_d = GET_ARG;
          end else if (rx_data == 8'h4C) begin
            cmd_d   = CMD_L;
            state_d = GET_ARG;
          end else if (rx_data == 8'h54) begin
            cmd_d   = CMD_T;
            state_d = GET_ARG;
          end else if (rx_data != CH_OPEN) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        GET_ARG: begin
          if (arg_in_range) begin
            arg_d   = digit_val;
            state_d = GET_END;
          end else begin
            err_d   = 1'b1;
            state_d = (rx_data == CH_OPEN) ? GET_CMD : IDLE;
          end
        end
        default: begin
          if (rx_data == CH_CLOSE) begin
            ok_d    = 1'b1;
            state_d = IDLE;
            case (cmd_q)
              CMD_S:   fan_d   = arg_q[1:0];
              CMD_L:   light_d = arg_q[0];
              default: begin
                timer_d = arg_q;
                load_d  = 1'b1;
              end
            endcase
          end else begin
            err_d   = 1'b1;
            state_d = (rx_data == CH_OPEN) ? GET_CMD : IDLE;
          end
        end
      endcase
    end else if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (cnt_q == TO_LAST) begin
      err_d   = 1'b1;
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cmd_q   <= CMD_S;
      arg_q   <= '0;
      cnt_q   <= '0;
      fan_q   <= '0;
      light_q <= 1'b0;
      timer_q <= '0;
      load_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      arg_q   <= arg_d;
      cnt_q   <= cnt_d;
      fan_q   <= fan_d;
      light_q <= light_d;
      timer_q <= timer_d;
      load_q  <= load_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign fan_speed  = fan_q;
  assign light_on   = light_q;
  assign timer_val  = timer_q;
  assign timer_load = load_q;
  assign cmd_ok     = ok_q;
  assign cmd_err    = err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_bt_fan_cmd_parser.sv
// Directed bench for bt_fan_cmd_parser: frames, range errors, timeout,
// resync and async reset, with hand-computed expectations.
module tb_bt_fan_cmd_parser;

  logic       clk;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [1:0] fan_speed;
  logic       light_on;
  logic [3:0] timer_val;
  logic       timer_load;
  logic       cmd_ok;
  logic       cmd_err;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;
  int okCount     = 0;
  int errCount    = 0;
  int loadCount   = 0;

  bt_fan_cmd_parser #(.TIMEOUT_CYC(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .fan_speed (fan_speed),
    .light_on  (light_on),
    .timer_val (timer_val),
    .timer_load(timer_load),
    .cmd_ok    (cmd_ok),
    .cmd_err   (cmd_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  // Pulses last one cycle, so sampling on the falling edge counts each exactly once.
  always @(negedge clk) begin
    if (cmd_ok) okCount++;
    if (cmd_err) errCount++;
    if (timer_load) loadCount++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Presents one byte for one cycle starting at a falling edge; returns on the
  // falling edge right after it was sampled, so registered results are visible.
  task automatic applyStimulus(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic sendSpaced(input logic [7:0] b);
    applyStimulus(b);
    idleCycles(1);
  endtask

  initial begin
    reset_n  = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    idleCycles(2);
    checkOutput("reset fan_speed", int'(fan_speed), 0);
    checkOutput("reset light_on", int'(light_on), 0);
    checkOutput("reset timer_val", int'(timer_val), 0);
    checkOutput("reset pulses", int'({timer_load, cmd_ok, cmd_err}), 0);
    checkOutput("reset busy", int'(busy), 0);
    reset_n = 1'b1;
    idleCycles(1);

    // <S2>
    applyStimulus(8'h3C);
    checkOutput("busy after open", int'(busy), 1);
    idleCycles(1);
    sendSpaced(8'h53);
    sendSpaced(8'h32);
    applyStimulus(8'h3E);
    checkOutput("S2 cmd_ok", int'(cmd_ok), 1);
    checkOutput("S2 fan_speed", int'(fan_speed), 2);
    checkOutput("S2 timer_load", int'(timer_load), 0);
    idleCycles(1);
    checkOutput("S2 cmd_ok drop", int'(cmd_ok), 0);
    checkOutput("S2 busy idle", int'(busy), 0);
    checkOutput("S2 ok count", okCount, 1);
    checkOutput("S2 err count", errCount, 0);

    // <T7> then <L1>
    sendSpaced(8'h3C);
    sendSpaced(8'h54);
    sendSpaced(8'h37);
    applyStimulus(8'h3E);
    checkOutput("T7 pulses", int'({timer_load, cmd_ok}), 3);
    checkOutput("T7 timer_val", int'(timer_val), 7);
    idleCycles(1);
    checkOutput("T7 load drop", int'(timer_load), 0);
    sendSpaced(8'h3C);
    sendSpaced(8'h4C);
    sendSpaced(8'h31);
    applyStimulus(8'h3E);
    checkOutput("L1 light_on", int'(light_on), 1);
    checkOutput("L1 no load", int'(timer_load), 0);
    idleCycles(1);
    checkOutput("L1 fan_speed held", int'(fan_speed), 2);
    checkOutput("L1 timer_val held", int'(timer_val), 7);
    checkOutput("L1 ok count", okCount, 3);
    checkOutput("L1 load count", loadCount, 1);

    // <S5> is out of range; trailing '>' must be ignored in IDLE
    sendSpaced(8'h3C);
    sendSpaced(8'h53);
    applyStimulus(8'h35);
    checkOutput("S5 cmd_err", int'(cmd_err), 1);
    checkOutput("S5 busy", int'(busy), 0);
    idleCycles(1);
    sendSpaced(8'h3E);
    idleCycles(1);
    checkOutput("S5 err count", errCount, 1);
    checkOutput("S5 fan_speed held", int'(fan_speed), 2);
    checkOutput("S5 ok count", okCount, 3);

    // Timeout: err exactly 15 cycles after the last sampled byte
    sendSpaced(8'h3C);
    applyStimulus(8'h53);
    idleCycles(14);
    checkOutput("timeout early err", int'(cmd_err), 0);
    checkOutput("timeout early busy", int'(busy), 1);
    idleCycles(1);
    checkOutput("timeout cmd_err", int'(cmd_err), 1);
    checkOutput("timeout busy", int'(busy), 0);
    idleCycles(5);
    sendSpaced(8'h3E);
    idleCycles(1);
    checkOutput("timeout err count", errCount, 2);
    checkOutput("timeout ok count", okCount, 3);

    // A byte landing on the expiry cycle wins over the timeout
    sendSpaced(8'h3C);
    applyStimulus(8'h53);
    idleCycles(14);
    applyStimulus(8'h33);
    checkOutput("expiry byte no err", int'(cmd_err), 0);
    checkOutput("expiry byte busy", int'(busy), 1);
    applyStimulus(8'h3E);
    checkOutput("expiry S3 cmd_ok", int'(cmd_ok), 1);
    checkOutput("expiry S3 fan_speed", int'(fan_speed), 3);
    idleCycles(1);
    checkOutput("expiry err count", errCount, 2);

    // Resync: <S<L0>
    sendSpaced(8'h3C);
    sendSpaced(8'h53);
    applyStimulus(8'h3C);
    checkOutput("resync cmd_err", int'(cmd_err), 1);
    checkOutput("resync busy", int'(busy), 1);
    idleCycles(1);
    sendSpaced(8'h4C);
    sendSpaced(8'h30);
    applyStimulus(8'h3E);
    checkOutput("resync cmd_ok", int'(cmd_ok), 1);
    checkOutput("resync light_on", int'(light_on), 0);
    idleCycles(1);
    checkOutput("resync err count", errCount, 3);

    // Back-to-back bytes: <T9>
    applyStimulus(8'h3C);
    applyStimulus(8'h54);
    applyStimulus(8'h39);
    applyStimulus(8'h3E);
    checkOutput("b2b pulses", int'({timer_load, cmd_ok}), 3);
    checkOutput("b2b timer_val", int'(timer_val), 9);
    idleCycles(1);
    checkOutput("b2b load count", loadCount, 2);

    // Async reset mid-frame, then a clean frame
    sendSpaced(8'h3C);
    sendSpaced(8'h54);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async fan_speed", int'(fan_speed), 0);
    checkOutput("async timer_val", int'(timer_val), 0);
    checkOutput("async busy", int'(busy), 0);
    idleCycles(2);
    reset_n = 1'b1;
    idleCycles(1);
    sendSpaced(8'h3C);
    sendSpaced(8'h53);
    sendSpaced(8'h31);
    applyStimulus(8'h3E);
    checkOutput("post-reset cmd_ok", int'(cmd_ok), 1);
    checkOutput("post-reset fan_speed", int'(fan_speed), 1);
    checkOutput("post-reset light_on", int'(light_on), 0);
    idleCycles(1);
    checkOutput("final err count", errCount, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
